// File: rtl/te_block_buffer.sv
// Trace-encoder block buffer: circular FIFO between the block FSM and the packet encoder,
// with sticky overflow flag and saturating count of dropped blocks.

package mure_pkg;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned IRETIRE_LEN = 32;
  localparam int unsigned ITYPE_LEN   = 3;
  localparam int unsigned CAUSE_LEN   = 5;
  localparam int unsigned PRIV_LEN    = 2;
endpackage

module te_block_buffer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_LEN = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               valid_i,
  input  logic [mure_pkg::IRETIRE_LEN-1:0]   iretire_i,
  input  logic                               ilastsize_i,
  input  logic [mure_pkg::ITYPE_LEN-1:0]     itype_i,
  input  logic [mure_pkg::CAUSE_LEN-1:0]     cause_i,
  input  logic [mure_pkg::XLEN-1:0]          tval_i,
  input  logic [mure_pkg::PRIV_LEN-1:0]      priv_i,
  input  logic [mure_pkg::XLEN-1:0]          iaddr_i,
  input  logic                               ready_i,
  input  logic                               clear_i,
  output logic                               valid_o,
  output logic [mure_pkg::IRETIRE_LEN-1:0]   iretire_o,
  output logic                               ilastsize_o,
  output logic [mure_pkg::ITYPE_LEN-1:0]     itype_o,
  output logic [mure_pkg::CAUSE_LEN-1:0]     cause_o,
  output logic [mure_pkg::XLEN-1:0]          tval_o,
  output logic [mure_pkg::PRIV_LEN-1:0]      priv_o,
  output logic [mure_pkg::XLEN-1:0]          iaddr_o,
  output logic [$clog2(DEPTH):0]             count_o,
  output logic                               full_o,
  output logic                               empty_o,
  output logic                               overflow_o,
  output logic [CNT_LEN-1:0]                 lost_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef struct packed {
    logic [mure_pkg::IRETIRE_LEN-1:0] iretire;
    logic                             ilastsize;
    logic [mure_pkg::ITYPE_LEN-1:0]   itype;
    logic [mure_pkg::CAUSE_LEN-1:0]   cause;
    logic [mure_pkg::XLEN-1:0]        tval;
    logic [mure_pkg::PRIV_LEN-1:0]    priv;
    logic [mure_pkg::XLEN-1:0]        iaddr;
  } blk_t;

  blk_t               mem_q [DEPTH];
  blk_t               wr_blk;
  blk_t               head;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [CNT_LEN-1:0] lost_q, lost_d;
  logic               offer, push, pop, drop, not_empty;

  assign wr_blk = '{
    iretire:   iretire_i,
    ilastsize: ilastsize_i,
    itype:     itype_i,
    cause:     cause_i,
    tval:      tval_i,
    priv:      priv_i,
    iaddr:     iaddr_i
  };

  // A block with no retired instructions carries nothing worth encoding.
  assign offer     = valid_i && (iretire_i != '0);
  assign not_empty = (count_q != '0);
  assign pop       = not_empty && ready_i;
  assign push      = offer && ((count_q < DepthCnt) || pop);
  assign drop      = offer && !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear beats a same-cycle drop for the flag, but that drop is still counted.
  always_comb begin
    overflow_d = overflow_q;
    lost_d     = lost_q;
    if (clear_i) begin
      overflow_d = 1'b0;
      lost_d     = drop ? CNT_LEN'(1) : '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (lost_q != '1) lost_d = lost_q + CNT_LEN'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      lost_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      lost_q     <= lost_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem_q[wr_ptr_q] <= wr_blk;
  end

  assign head = not_empty ? mem_q[rd_ptr_q] : '0;

  assign valid_o     = not_empty;
  assign empty_o     = !not_empty;
  assign full_o      = (count_q == DepthCnt);
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign lost_o      = lost_q;
  assign iretire_o   = head.iretire;
  assign ilastsize_o = head.ilastsize;
  assign itype_o     = head.itype;
  assign cause_o     = head.cause;
  assign tval_o      = head.tval;
  assign priv_o      = head.priv;
  assign iaddr_o     = head.iaddr;

endmodule

// File: doc/te_block_buffer.md
TE_BLOCK_BUFFER -- requirements
Module: te_block_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of block entries; legal values are powers of two with DEPTH >= 2.
REQ-002 SHALL have parameter CNT_LEN, default 16, meaning the width of the dropped-block counter.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port valid_i  input  1  block present on the block inputs this cycle.
REQ-006 SHALL have ports iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i  input  mure_pkg::IRETIRE_LEN, 1, ITYPE_LEN, CAUSE_LEN, XLEN, PRIV_LEN, XLEN  one completed block from the FSM stage.
REQ-007 SHALL have port ready_i  input  1  encoder accepts the head block.
REQ-008 SHALL have port clear_i  input  1  clears overflow_o and lost_o.
REQ-009 SHALL have port valid_o  output  1  head block available.
REQ-010 SHALL have ports iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o  output  same widths as REQ-006  head block fields.
REQ-011 SHALL have port count_o  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 SHALL have ports full_o and empty_o  output  1 each  occupancy flags.
REQ-013 SHALL have port overflow_o  output  1  sticky flag: a block was dropped.
REQ-014 SHALL have port lost_o  output  CNT_LEN  saturating count of dropped blocks.

Function
REQ-015 SHALL treat the block inputs as an offer when valid_i=1 and iretire_i!=0; valid_i=1 with iretire_i==0 SHALL be discarded silently, with no push, no overflow and no count.
REQ-016 SHALL store entries in a circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 SHALL perform a push when there is an offer and (count_o<DEPTH or pop occurs in the same cycle).
REQ-018 SHALL perform a pop when valid_o=1 and ready_i=1.
REQ-019 SHALL make a pushed block visible on the outputs no earlier than the cycle after the push: one-cycle latency, no combinational fall-through from inputs to outputs.
REQ-020 SHALL drive valid_o = (count_o!=0), empty_o = (count_o==0) and full_o = (count_o==DEPTH).
REQ-021 SHALL drive the outputs from the entry at the read pointer and hold them stable while valid_o=1 and ready_i=0.
REQ-022 SHALL update count_o as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop, including at full and at count 1.
REQ-023 SHALL, when full with an offer and no pop, drop the offer, set overflow_o=1 next cycle and increment lost_o, with lost_o saturating at all-ones.
REQ-024 SHALL, when clear_i=1, clear overflow_o and lost_o next cycle; if a drop occurs in the same cycle, clear SHALL win for overflow_o and lost_o SHALL load 1.
REQ-025 SHALL not affect buffered entries or pointers when clear_i is asserted.
REQ-026 SHALL drive all block data outputs to 0 whenever valid_o=0.
REQ-027 SHALL preserve FIFO order exactly; no merging or reordering of blocks.

Reset
REQ-028 SHALL, on rst_i=1 at a clock edge, set pointers=0, count_o=0, valid_o=0, empty_o=1, full_o=0, overflow_o=0, lost_o=0 and all data outputs=0.
REQ-029 SHALL make an offer or pop in the reset cycle have no effect, and SHALL discard contents on reset asserted mid-operation.
REQ-030 SHALL not require storage array contents to be reset.

Verification
REQ-031 Scenario: push one block (iretire=5, iaddr=0x8000_0000) with ready_i=0 -> next cycle valid_o=1, iretire_o=5, iaddr_o=0x8000_0000, count_o=1; held until ready_i=1; then empty_o=1.
REQ-032 Scenario: DEPTH=8, push 10 blocks with ready_i=0 -> full_o=1 after 8, overflow_o=1, lost_o=2; then drain -> 8 blocks in push order.
REQ-033 Scenario: full with offer and ready_i=1 in the same cycle -> both accepted, count_o stays 8, lost_o unchanged.
REQ-034 Scenario: valid_i=1 with iretire_i=0 -> count_o unchanged, overflow_o=0.
REQ-035 Scenario: 20 push/pop cycles with random ready_i (pointer wrap) -> output order matches input; then rst_i=1 while count_o=3 -> next cycle count_o=0, valid_o=0.
REQ-036 Scenario: lost_o saturated at 0xFFFF with a further drop -> lost_o stays 0xFFFF; clear_i=1 -> 0, overflow_o=0.
